psola_stream_buffer: RTL

Parametrised output-side playback buffer for the autotune pipeline. It accepts the PSOLA engine's output stream through a valid/ready handshake, stores it in a ring buffer and emits one sample every N clock cycles to the audio DAC path. It generalises the existing fixed-size, fixed-rate buffering with:
- configurable data width, depth and prefill threshold;
- a runtime-adjustable sample period;
- upstream backpressure, underflow recovery and a synchronous flush.

---
 rtl/psola_stream_buffer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/psola_stream_buffer.sv
// -----------------------------------------------------------------------------
// psola_stream_buffer
//
// Output-side playback buffer for the autotune pipeline. Words from the PSOLA
// engine arrive over a valid/ready handshake, are stored in a ring buffer and
// are released one at a time to the DAC path, one every `period` clocks.
// Playback starts once PREFILL words are buffered. An empty buffer at a sample
// tick emits a filler word, so the DAC cadence is kept, and drops back to
// filling.
//
// Ports
//   clk_in          : clock, all logic on rising edge
//   rst_n_in        : asynchronous active-low reset
//   wr_data_in      : sample word from PSOLA
//   wr_valid_in     : wr_data_in valid
//   wr_ready_out    : buffer accepts a word (transfer on valid && ready)
//   cps_in          : new sample period in clocks (clamped to >= 2)
//   cps_valid_in    : load cps_in into the pending period register
//   flush_in        : synchronous clear of buffer contents
//   audio_out       : played sample
//   audio_valid_out : one-cycle strobe, audio_out valid
//   underflow_out   : one-cycle strobe, a tick found the buffer empty
//   level_out       : current occupancy
//   playing_out     : buffer is in the PLAYING state
// -----------------------------------------------------------------------------
module psola_stream_buffer #(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 4400,
    parameter int PREFILL           = 2200,
    parameter int CYCLES_PER_SAMPLE = 2304,
    parameter int UNDERFLOW_MODE    = 0
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [DATA_WIDTH-1:0]        wr_data_in,
    input  logic                         wr_valid_in,
    output logic                         wr_ready_out,
    input  logic [15:0]                  cps_in,
    input  logic                         cps_valid_in,
    input  logic                         flush_in,
    output logic [DATA_WIDTH-1:0]        audio_out,
    output logic                         audio_valid_out,
    output logic                         underflow_out,
    output logic [$clog2(DEPTH+1)-1:0]   level_out,
    output logic                         playing_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        S_FILLING = 1'b0,
        S_PLAYING = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [15:0]           r_cnt;
    logic [15:0]           r_period;
    logic [15:0]           r_pend;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_mem_rd;
    logic [DATA_WIDTH-1:0] r_alt;
    logic                  r_use_mem;
    logic                  r_avalid;
    logic                  r_uf;

    logic                  w_empty;
    logic                  w_wr;
    logic                  w_tick;
    logic                  w_pop;
    logic                  w_uf;
    logic [DATA_WIDTH-1:0] w_audio;

    function automatic logic [15:0] clamp_period(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty      = (r_level == '0);
    // Ready comes from the registered level only; flush forces it low so a
    // same-cycle write is refused rather than silently lost by the clear.
    assign wr_ready_out = (r_level < LW'(DEPTH)) && !flush_in;
    assign w_wr         = wr_valid_in && wr_ready_out;
    // Flush cancels a tick landing in the same cycle.
    assign w_tick       = (r_state == S_PLAYING) && (r_cnt == r_period - 16'd1) && !flush_in;
    assign w_pop        = w_tick && !w_empty;
    assign w_uf         = w_tick && w_empty;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_FILLING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush_in) begin
            w_state_nxt = S_FILLING;
        end else begin
            case (r_state)
                S_FILLING: if (r_level >= LW'(PREFILL)) w_state_nxt = S_PLAYING;
                S_PLAYING: if (w_uf)                    w_state_nxt = S_FILLING;
                default:                                w_state_nxt = S_FILLING;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        playing_out = (r_state == S_PLAYING);
    end

    // Pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample-period counter; it is 0 whenever the buffer is not playing, so
    // entering PLAYING always starts a fresh interval.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt <= '0;
        end else if (flush_in || r_state != S_PLAYING || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Pending period is taken over at an interval boundary so an interval in
    // progress is never stretched or cut short; while filling it tracks at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend   <= 16'(CYCLES_PER_SAMPLE);
            r_period <= 16'(CYCLES_PER_SAMPLE);
        end else begin
            if (cps_valid_in) r_pend <= clamp_period(cps_in);
            if (r_state == S_FILLING || w_tick) r_period <= r_pend;
        end
    end

    // Storage: no reset so the array and its read register map onto block RAM.
    always_ff @(posedge clk_in) begin
        if (w_wr)  r_mem[r_wr_ptr] <= wr_data_in;
        if (w_pop) r_mem_rd        <= r_mem[r_rd_ptr];
    end

    // Output side. The RAM read register cannot be reset, so audio_out selects
    // between it and a resettable filler register; the filler is loaded on an
    // underflow with zero or with the word currently on the output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_avalid  <= 1'b0;
            r_uf      <= 1'b0;
            r_use_mem <= 1'b0;
            r_alt     <= '0;
        end else begin
            r_avalid <= w_tick;
            r_uf     <= w_uf;
            if (w_pop) begin
                r_use_mem <= 1'b1;
            end else if (w_uf) begin
                r_use_mem <= 1'b0;
                r_alt     <= (UNDERFLOW_MODE != 0) ? w_audio : '0;
            end
        end
    end

    assign w_audio         = r_use_mem ? r_mem_rd : r_alt;
    assign audio_out       = w_audio;
    assign audio_valid_out = r_avalid;
    assign underflow_out   = r_uf;
    assign level_out       = r_level;

endmodule
